icache_refill: RTL

//  I-cache miss handler, between the fetch-stage I-cache and the instruction-memory bus bridge.

---
 rtl/cpu_consts.sv | 38 +++
 rtl/icache_refill.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_consts.sv
// Shared CPU constants and bus/cache record types.
// Used by the instruction-side refill path.
package cpu_consts;

    // Refill engine states. The engine keeps them as plain 2-bit constants.
    typedef enum logic [1:0] {
        RF_IDLE   = 2'd0,
        RF_REQ    = 2'd1,
        RF_DATA   = 2'd2,
        RF_COMMIT = 2'd3
    } refill_state_t;

    localparam int          LINE_BEATS      = 8;
    localparam logic [1:0]  IMEM_BURST_WRAP = 2'b10;
    localparam logic [2:0]  IMEM_SIZE_8B    = 3'd3;

    // Instruction-memory burst read request.
    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } imem_req_t;

    // One read beat returned by the bridge.
    typedef struct packed {
        logic        error;
        logic        last;
        logic [63:0] data;
    } fifo_entry_t;

    // Tag-array entry for a 128-set, 64-byte-line cache.
    typedef struct packed {
        logic        valid;
        logic [50:0] tag;
    } cache_tag_t;

endpackage

// File: rtl/icache_refill.sv
// I-cache miss handler: invalidates the victim set, issues one wrapping
// burst for the 64-byte line, streams the beats into the data array,
// forwards the critical word, and reinstalls the tag on a clean fill.
module icache_refill
    import cpu_consts::*;
#(
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 51,
    parameter int LINE_BEATS = cpu_consts::LINE_BEATS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic [63:0]        miss_addr,
    input  logic               flush,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output imem_req_t          imem_req,
    input  logic               beat_valid,
    output logic               beat_ready,
    input  fifo_entry_t        beat,
    output logic               data_wr_en,
    output logic [INDEX_W-1:0] data_wr_index,
    output logic [2:0]         data_wr_word,
    output logic [63:0]        data_wr_data,
    output logic               tag_wr_en,
    output logic [INDEX_W-1:0] tag_wr_index,
    output cache_tag_t         tag_wr_data,
    output logic               cw_valid,
    output logic [63:0]        cw_data,
    output logic               refill_done,
    output logic               refill_error
);

    localparam logic [1:0] ST_IDLE   = RF_IDLE;
    localparam logic [1:0] ST_REQ    = RF_REQ;
    localparam logic [1:0] ST_DATA   = RF_DATA;
    localparam logic [1:0] ST_COMMIT = RF_COMMIT;

    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    logic [1:0]  state_reg,    state_next;
    logic [63:3] addr_reg,     addr_next;
    logic [2:0]  beat_cnt_reg, beat_cnt_next;
    logic        killed_reg,   killed_next;
    logic        err_reg,      err_next;

    // Byte offset within a word never matters: requests are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^miss_addr[2:0];

    // Line index and tag of the miss being serviced.
    logic [INDEX_W-1:0] cur_index;
    logic [TAG_W-1:0]   cur_tag;
    assign cur_index = addr_reg[6 +: INDEX_W];
    assign cur_tag   = addr_reg[63 -: TAG_W];

    // Next-state, output decode and beat protocol checking.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        beat_cnt_next  = beat_cnt_reg;
        killed_next    = killed_reg;
        err_next       = err_reg;

        miss_ready     = 1'b0;
        imem_req_valid = 1'b0;
        imem_req       = '0;
        beat_ready     = 1'b0;
        data_wr_en     = 1'b0;
        data_wr_index  = '0;
        data_wr_word   = '0;
        data_wr_data   = '0;
        tag_wr_en      = 1'b0;
        tag_wr_index   = '0;
        tag_wr_data    = '0;
        cw_valid       = 1'b0;
        cw_data        = '0;
        refill_done    = 1'b0;
        refill_error   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    // Invalidate the set up front so a partial fill is never hit.
                    tag_wr_en     = 1'b1;
                    tag_wr_index  = miss_addr[6 +: INDEX_W];
                    addr_next     = miss_addr[63:3];
                    beat_cnt_next = 3'd0;
                    killed_next   = flush;
                    err_next      = 1'b0;
                    state_next    = ST_REQ;
                end
            end

            ST_REQ: begin
                imem_req_valid = 1'b1;
                imem_req.addr  = {addr_reg, 3'b000};
                imem_req.len   = 8'(LINE_BEATS - 1);
                imem_req.size  = IMEM_SIZE_8B;
                imem_req.burst = IMEM_BURST_WRAP;
                killed_next    = killed_reg | flush;
                if (imem_req_ready) begin
                    state_next = ST_DATA;
                end
            end

            ST_DATA: begin
                beat_ready    = 1'b1;
                killed_next   = killed_reg | flush;
                data_wr_index = cur_index;
                data_wr_word  = addr_reg[5:3] + beat_cnt_reg;
                data_wr_data  = beat.data;
                cw_data       = beat.data;
                if (beat_valid) begin
                    data_wr_en    = 1'b1;
                    cw_valid      = (beat_cnt_reg == 3'd0) && !killed_reg && !beat.error;
                    beat_cnt_next = beat_cnt_reg + 3'd1;
                    // Error beats and a misplaced or missing last both spoil the line.
                    if (beat.error || (beat.last != (beat_cnt_reg == LAST_BEAT))) begin
                        err_next = 1'b1;
                    end
                    if (beat.last || beat_cnt_reg == LAST_BEAT) begin
                        state_next = ST_COMMIT;
                    end
                end
            end

            default: begin
                killed_next = killed_reg | flush;
                if (!err_reg) begin
                    tag_wr_en         = 1'b1;
                    tag_wr_index      = cur_index;
                    tag_wr_data.valid = 1'b1;
                    tag_wr_data.tag   = cur_tag;
                end
                refill_done  = !killed_reg && !err_reg;
                refill_error = !killed_reg && err_reg;
                state_next   = ST_IDLE;
            end
        endcase
    end

    // State and miss-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            killed_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            beat_cnt_reg <= beat_cnt_next;
            killed_reg   <= killed_next;
            err_reg      <= err_next;
        end
    end

endmodule
